// File: rtl/lsu_dmem_ctrl.sv
// RV64 load/store unit front-end for a 64-bit, doubleword-indexed data memory.
// Sub-doubleword stores use read-modify-write; loads are lane-extracted and extended.
module lsu_dmem_ctrl #(
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_done,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic        busy,
  output logic [63:0] dm_address,
  output logic [63:0] dm_WriteData,
  output logic        dm_MemRead,
  output logic        dm_MemWrite,
  input  logic [63:0] dm_ReadData
);

  localparam logic [63:0] DEPTH_W = 64'(DMEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RD,
    STORE_RD,
    STORE_WR,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] wdata_q, wdata_d;
  logic        is_load_q, is_load_d;
  logic        fault_q, fault_d;
  logic [63:0] data_q, data_d;

  // Request classification, evaluated on the raw inputs in IDLE
  logic req_illegal;
  logic req_misaligned;
  logic req_out_of_range;
  logic req_fault;

  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
  end

  assign req_illegal      = (req_load == req_store)
                          | (req_load & (req_funct3 == 3'b111))
                          | (req_store & req_funct3[2]);
  assign req_out_of_range = (req_addr >> 3) >= DEPTH_W;
  assign req_fault        = req_illegal | req_misaligned | req_out_of_range;

  // Byte-lane geometry of the latched access
  logic [2:0]  lane_k;
  logic [3:0]  nbytes;
  logic [7:0]  lane_en;
  logic [63:0] wdata_shift;
  logic [63:0] merged;
  logic [63:0] rd_shift;
  logic [63:0] load_ext;

  assign lane_k      = addr_q[2:0];
  assign nbytes      = 4'd1 << funct3_q[1:0];
  assign wdata_shift = wdata_q << {lane_k, 3'b000};
  assign rd_shift    = dm_ReadData >> {lane_k, 3'b000};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_en[gi] = (4'(gi) >= {1'b0, lane_k}) &&
                           (4'(gi) < ({1'b0, lane_k} + nbytes));
      assign merged[8*gi +: 8] = lane_en[gi] ? wdata_shift[8*gi +: 8]
                                             : dm_ReadData[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_ext = rd_shift;
    case (funct3_q)
      3'b000:  load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  load_ext = {56'd0, rd_shift[7:0]};
      3'b101:  load_ext = {48'd0, rd_shift[15:0]};
      3'b110:  load_ext = {32'd0, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    wdata_d   = wdata_q;
    is_load_d = is_load_q;
    fault_d   = fault_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          funct3_d  = req_funct3;
          wdata_d   = req_wdata;
          is_load_d = req_load;
          fault_d   = req_fault;
          data_d    = 64'd0;
          if (req_fault) begin
            state_d = DONE;
          end else if (req_load) begin
            state_d = LOAD_RD;
          end else if (req_funct3 == 3'b011) begin
            // Full doubleword store needs no read of the old contents
            data_d  = req_wdata;
            state_d = STORE_WR;
          end else begin
            state_d = STORE_RD;
          end
        end
      end
      LOAD_RD: begin
        data_d  = load_ext;
        state_d = DONE;
      end
      STORE_RD: begin
        data_d  = merged;
        state_d = STORE_WR;
      end
      STORE_WR: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= 64'd0;
      funct3_q  <= 3'd0;
      wdata_q   <= 64'd0;
      is_load_q <= 1'b0;
      fault_q   <= 1'b0;
      data_q    <= 64'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
      is_load_q <= is_load_d;
      fault_q   <= fault_d;
      data_q    <= data_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset kills them at once
  logic mem_phase;
  assign mem_phase    = (state_q == LOAD_RD) || (state_q == STORE_RD) || (state_q == STORE_WR);
  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign dm_MemRead   = (state_q == LOAD_RD) || (state_q == STORE_RD);
  assign dm_MemWrite  = (state_q == STORE_WR);
  assign dm_address   = mem_phase ? {3'b000, addr_q[63:3]} : 64'd0;
  assign dm_WriteData = (state_q == STORE_WR) ? data_q : 64'd0;
  assign resp_done    = (state_q == DONE);
  assign resp_fault   = (state_q == DONE) && fault_q;
  assign resp_rdata   = ((state_q == DONE) && is_load_q && !fault_q) ? data_q : 64'd0;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: directed cases plus random traffic against a
// byte-level reference model of memory and of the request/response protocol.
module tb_lsu_dmem_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_done;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        busy;
  logic [63:0] dm_address;
  logic [63:0] dm_WriteData;
  logic        dm_MemRead;
  logic        dm_MemWrite;
  logic [63:0] dm_ReadData;

  lsu_dmem_ctrl #(.DMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .busy(busy),
    .dm_address(dm_address), .dm_WriteData(dm_WriteData),
    .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
    .dm_ReadData(dm_ReadData)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(int i);
    logic [63:0] v;
    v = {32'(i) * 32'h9E3779B9, ~(32'(i) * 32'h85EBCA6B)};
    return v;
  endfunction

  // Data memory as seen by the DUT: combinational read, posedge write
  logic [63:0] dmem [DEPTH];
  assign dm_ReadData = dmem[dm_address[9:0]];
  initial begin
    for (int i = 0; i < DEPTH; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (dm_MemWrite) dmem[dm_address[9:0]] <= dm_WriteData;
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [DEPTH];

  function automatic int m_size(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(bit ld, bit st, logic [2:0] f3, logic [63:0] a);
    if (ld == st) return 1'b1;
    if (ld && f3 == 3'b111) return 1'b1;
    if (st && f3[2]) return 1'b1;
    if ((a % 64'(m_size(f3))) != 0) return 1'b1;
    if ((a / 8) >= 64'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_load(logic [63:0] word, logic [2:0] k, logic [2:0] f3);
    logic [63:0] v;
    int n;
    n = m_size(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(int'(k)+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] m_store(logic [63:0] word, logic [2:0] k, logic [2:0] f3,
                                          logic [63:0] wd);
    logic [63:0] v;
    v = word;
    for (int i = 0; i < m_size(f3); i++) v[8*(int'(k)+i) +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  bit          mon_en = 1'b1;
  bit          pend = 1'b0;
  int          mon_n = 0;
  int          exp_lat;
  bit          exp_rd, exp_wr, exp_fault;
  logic [63:0] exp_idx, exp_wdata, exp_rdata;
  logic [63:0] last_rdata;
  logic        last_fault;
  int          txn = 0;

  // Called at every negedge: outputs are checked against the pending expectation
  task automatic monitor();
    bit e_done, e_rd, e_wr;
    if (!mon_en) return;
    chk("rd_wr_exclusive", {63'd0, dm_MemRead & dm_MemWrite}, 64'd0);
    if (pend) begin
      mon_n++;
      e_done = (mon_n == exp_lat);
      e_rd   = exp_rd && (mon_n == 1);
      e_wr   = exp_wr && (mon_n == exp_lat - 1);
      chk("busy", {63'd0, busy}, 64'd1);
      chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
      chk("resp_done", {63'd0, resp_done}, {63'd0, e_done});
      chk("dm_MemRead", {63'd0, dm_MemRead}, {63'd0, e_rd});
      chk("dm_MemWrite", {63'd0, dm_MemWrite}, {63'd0, e_wr});
      chk("dm_address", dm_address, (e_rd || e_wr) ? exp_idx : 64'd0);
      if (e_wr) chk("dm_WriteData", dm_WriteData, exp_wdata);
      if (e_done) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_fault", {63'd0, resp_fault}, {63'd0, exp_fault});
        last_rdata = resp_rdata;
        last_fault = resp_fault;
        $display("txn %0d lat=%0d fault=%0d rdata=%h", txn, exp_lat, resp_fault, resp_rdata);
        pend = 1'b0;
        txn++;
      end
    end else begin
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_ready", {63'd0, req_ready}, 64'd1);
      chk("idle_done", {63'd0, resp_done}, 64'd0);
      chk("idle_strobes", {62'd0, dm_MemRead, dm_MemWrite}, 64'd0);
      chk("idle_address", dm_address, 64'd0);
      chk("idle_rdata", resp_rdata, 64'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Drive one request (entered at posedge+1 with the DUT idle) and run it to completion
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    logic [9:0] ix;
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    exp_fault  = m_fault(ld, st, f3, a);
    exp_idx    = a >> 3;
    ix         = exp_idx[9:0];
    exp_rdata  = 64'd0;
    exp_wdata  = 64'd0;
    exp_rd     = 1'b0;
    exp_wr     = 1'b0;
    if (exp_fault) begin
      exp_lat = 1;
    end else if (ld) begin
      exp_lat   = 2;
      exp_rd    = 1'b1;
      exp_rdata = m_load(ref_mem[ix], a[2:0], f3);
    end else begin
      exp_wdata   = m_store(ref_mem[ix], a[2:0], f3, wd);
      ref_mem[ix] = exp_wdata;
      exp_wr      = 1'b1;
      exp_lat     = (m_size(f3) == 8) ? 2 : 3;
      exp_rd      = (m_size(f3) != 8);
    end
    tick();
    pend  = 1'b1;
    mon_n = 0;
    while (pend) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_load   = 1'($urandom_range(0, 1));
      req_store  = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = {$urandom, $urandom};
      req_wdata  = {$urandom, $urandom};
      tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] a, wd, saved;
    bit ld, st;
    logic [2:0] f3;
    int sz, lane;
    logic [63:0] idx;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Model pins
    chk("pin_lb",  m_load(64'h8877665544332211, 3'd7, 3'b000), 64'hFFFFFFFFFFFFFF88);
    chk("pin_lw",  m_load(64'h8877665544332211, 3'd4, 3'b010), 64'hFFFFFFFF88776655);
    chk("pin_lhu", m_load(64'h8877665544332211, 3'd2, 3'b101), 64'h0000000000004433);
    chk("pin_sb",  m_store(64'h8877665544332211, 3'd3, 3'b000, 64'hAB), 64'h88776655AB332211);

    // Reset held with a request pending
    rst = 1'b0; req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_funct3 = 3'b011; req_addr = 64'h10; req_wdata = 64'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_wdata", dm_WriteData, 64'd0);
      chk("rst_fault", {63'd0, resp_fault}, 64'd0);
    end
    rst = 1'b1;
    issue(1'b1, 1'b0, 3'b011, 64'h10, 64'd0);
    chk("rst_release_ld", last_rdata, init_word(2));

    // SD then LD
    issue(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211);
    chk("sd_mem", dmem[2], 64'h8877665544332211);
    issue(1'b1, 1'b0, 3'b011, 64'h10, 64'd0);
    chk("ld_rdata", last_rdata, 64'h8877665544332211);

    // SB merge
    issue(1'b0, 1'b1, 3'b000, 64'h13, 64'hAB);
    chk("sb_mem", dmem[2], 64'h88776655AB332211);

    // Extension cases on the original doubleword
    issue(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211);
    issue(1'b1, 1'b0, 3'b000, 64'h17, 64'd0);
    chk("lb", last_rdata, 64'hFFFFFFFFFFFFFF88);
    issue(1'b1, 1'b0, 3'b100, 64'h17, 64'd0);
    chk("lbu", last_rdata, 64'h0000000000000088);
    issue(1'b1, 1'b0, 3'b010, 64'h14, 64'd0);
    chk("lw", last_rdata, 64'hFFFFFFFF88776655);
    issue(1'b1, 1'b0, 3'b101, 64'h12, 64'd0);
    chk("lhu", last_rdata, 64'h0000000000004433);

    // Faults
    issue(1'b1, 1'b0, 3'b010, 64'h12, 64'd0);
    chk("fault_lw_mis", {63'd0, last_fault}, 64'd1);
    issue(1'b0, 1'b1, 3'b001, 64'h11, 64'h1234);
    chk("fault_sh_mis", {63'd0, last_fault}, 64'd1);
    issue(1'b1, 1'b0, 3'b011, 64'h2000, 64'd0);
    chk("fault_ld_range", {63'd0, last_fault}, 64'd1);
    issue(1'b1, 1'b0, 3'b111, 64'h10, 64'd0);
    chk("fault_f3_111", {63'd0, last_fault}, 64'd1);
    issue(1'b1, 1'b1, 3'b011, 64'h10, 64'd0);
    chk("fault_ld_st", {63'd0, last_fault}, 64'd1);
    chk("fault_mem_kept", dmem[2], 64'h8877665544332211);

    // Reset during STORE_WR
    mon_en = 1'b0;
    saved = dmem[3];
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = 3'b000; req_addr = 64'h19; req_wdata = 64'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_wr_before", {63'd0, dm_MemWrite}, 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_wr_after", {63'd0, dm_MemWrite}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_mem", dmem[3], saved);
    rst = 1'b1;
    mon_en = 1'b1;
    tick();

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) tick();
      ld = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 15) == 0) ? ld : !ld;
      f3 = 3'($urandom_range(0, 7));
      sz = m_size(f3);
      if ($urandom_range(0, 9) == 0) idx = 64'(DEPTH) + 64'($urandom_range(0, 100));
      else idx = 64'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) lane = $urandom_range(0, 7);
      else lane = ($urandom_range(0, 7) / sz) * sz;
      a  = (idx << 3) + 64'(lane);
      wd = {$urandom, $urandom};
      issue(ld, st, f3, a, wd);
    end

    for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store controller between the single-cycle datapath and data_memory (64-bit words, doubleword-indexed, combinational read, posedge write).
- Converts byte-addressed RV64 loads/stores into doubleword accesses.
- Sub-doubleword stores are done as read-modify-write; load data is extracted and sign/zero-extended.
- Asserts a fault on misaligned or out-of-range accesses and issues no memory strobe for them.

Parameters:
- DMEM_DEPTH, 1024, number of 64-bit doublewords in data_memory; valid byte addresses are 0 .. 8*DMEM_DEPTH-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req_valid  input  1  request strobe, sampled only when req_ready=1
- req_ready  output  1  high only in IDLE
- req_load  input  1  request is a load
- req_store  input  1  request is a store
- req_funct3  input  3  RISC-V funct3 (size/sign)
- req_addr  input  64  byte address
- req_wdata  input  64  store data, low bytes used
- resp_done  output  1  one-cycle pulse, access finished
- resp_rdata  output  64  extended load data, valid while resp_done=1, else 0
- resp_fault  output  1  valid with resp_done; 1 = misaligned, out of range or illegal
- busy  output  1  high in every state except IDLE (stall to core)
- dm_address  output  64  doubleword index = addr>>3
- dm_WriteData  output  64  merged store doubleword
- dm_MemRead  output  1  read strobe to data_memory
- dm_MemWrite  output  1  write strobe to data_memory
- dm_ReadData  input  64  data_memory read data (combinational)

Behaviour:
Reset
- While rst=0: state=IDLE; all outputs 0 except req_ready=1; latched request cleared.
- dm_MemWrite is decoded from state, so it drops immediately on reset. A reset during STORE_WR before the edge produces no write.

State machine
- States: IDLE, LOAD_RD, STORE_RD, STORE_WR, DONE.

IDLE
- Accept occurs when req_valid=1. The edge latches addr, funct3, wdata, load/store and the fault flag.
- Fault if any of the following:
  - req_load==req_store;
  - load with funct3=111;
  - store with funct3[2]=1;
  - misaligned: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0;
  - addr>>3 >= DMEM_DEPTH.
- Next state:
  - fault -> DONE;
  - load -> LOAD_RD;
  - store with funct3=011 (SD) -> STORE_WR, with merged data = wdata;
  - other stores -> STORE_RD.

LOAD_RD
- dm_MemRead=1, dm_address=index.
- The edge captures dm_ReadData and byte lane k=addr[2:0] (little-endian: byte k = bits 8k+7:8k).
- Extension: LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD passes through.
- -> DONE.

STORE_RD
- dm_MemRead=1.
- The edge captures the old doubleword and replaces byte lanes k..k+size-1 with the low bytes of wdata.
- -> STORE_WR.

STORE_WR
- dm_MemWrite=1, dm_WriteData=merged, dm_address=index, dm_MemRead=0.
- Memory writes on this edge. -> DONE.

DONE
- resp_done=1 for exactly one cycle, with resp_rdata (0 for stores and faults) and resp_fault. -> IDLE.

Interface rules
- dm_address is 0 and strobes are 0 in IDLE and DONE.
- Latency from the accept edge to the resp_done cycle:
  - load: 2 cycles;
  - SD: 2 cycles;
  - SB/SH/SW: 3 cycles;
  - fault: 1 cycle.
- req_valid while busy is ignored; the request must be held or re-issued.
- req_wdata and req_addr may change after accept.
- Never both dm_MemRead and dm_MemWrite in one cycle.
- Back-to-back: a new request can be accepted in the cycle after DONE.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=1, busy=0, resp_done=0, no dm strobes; release -> request accepted next edge.
2. SD then LD: SD addr=0x10, wdata=0x8877665544332211 -> one dm_MemWrite at index 2 with 0x8877665544332211, done 2 cycles after accept. LD addr=0x10 -> resp_rdata=0x8877665544332211, fault=0.
3. SB merge: memory[2]=0x8877665544332211; SB addr=0x13, wdata=0xAB -> STORE_RD then write 0x88776655AB332211; done at cycle 3.
4. Extension: LB addr=0x17 -> 0xFFFFFFFFFFFFFF88; LBU addr=0x17 -> 0x88; LW addr=0x14 -> 0xFFFFFFFF88776655; LHU addr=0x12 -> 0x0000000000004433.
5. Faults: LW addr=0x12, SH addr=0x11, LD addr=0x2000 (DMEM_DEPTH=1024), load funct3=111, req_load=req_store=1 -> each gives resp_fault=1 one cycle after accept and zero dm strobes.
6. Reset mid-store: SB accepted, assert rst=0 during STORE_WR before the edge -> dm_MemWrite drops immediately, memory unchanged, IDLE after release.
